alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 150 +++++++++++++++
 tb/tb_alu_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin front end sharing one combinational ALU between two requesters; result valid 2 cycles after accept.
// Accepts only in IDLE, holds each response until consumed, so a stalled consumer stalls both requesters.
`ifndef ALU_CWIDTH
`define ALU_CWIDTH 4
`endif
`ifndef ALU_OP_ADD
`define ALU_OP_ADD  4'd0
`define ALU_OP_SUBU 4'd3
`define ALU_OP_AND  4'd4
`define ALU_OP_OR   4'd5
`define ALU_OP_CLZ  4'd10
`endif

module alu_arbiter #(
  parameter int CW = `ALU_CWIDTH
) (
  input  logic          iClk,
  input  logic          iRst_n,
  input  logic          iReqValid0,
  input  logic          iReqValid1,
  output logic          oReqReady0,
  output logic          oReqReady1,
  input  logic [31:0]   iA0,
  input  logic [31:0]   iB0,
  input  logic [31:0]   iA1,
  input  logic [31:0]   iB1,
  input  logic [CW-1:0] iOp0,
  input  logic [CW-1:0] iOp1,
  output logic          oRspValid0,
  output logic          oRspValid1,
  input  logic          iRspReady0,
  input  logic          iRspReady1,
  output logic [31:0]   oResult0,
  output logic [31:0]   oResult1,
  output logic [3:0]    oFlags0,
  output logic [3:0]    oFlags1,
  output logic [31:0]   oAluA,
  output logic [31:0]   oAluB,
  output logic [CW-1:0] oAluOp,
  input  logic [31:0]   iAluResult,
  input  logic          iAluZero,
  input  logic          iAluCarry,
  input  logic          iAluNegative,
  input  logic          iAluOverflow,
  output logic          oBusy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [31:0]   a;
    logic [31:0]   b;
    logic [CW-1:0] op;
  } opnd_t;

  state_t      rState;
  opnd_t       rOpnd;
  logic        rPrio;
  logic        rGrant;
  logic [31:0] rResult0;
  logic [31:0] rResult1;
  logic [3:0]  rFlags0;
  logic [3:0]  rFlags1;
  logic        rRspValid0;
  logic        rRspValid1;

  logic        pick0;
  logic        pick1;
  logic        rspDone;
  logic [3:0]  aluFlags;

  // Grant decision is kept free of the reset net; reset only masks the outputs.
  always_comb begin
    pick0 = 1'b0;
    pick1 = 1'b0;
    if (rState == IDLE) begin
      if (iReqValid0 && iReqValid1) begin
        pick0 = !rPrio;
        pick1 = rPrio;
      end else begin
        pick0 = iReqValid0;
        pick1 = iReqValid1;
      end
    end
  end

  assign rspDone  = (rState == RESP) &&
                    (rGrant ? (rRspValid1 && iRspReady1) : (rRspValid0 && iRspReady0));
  assign aluFlags = {iAluZero, iAluCarry, iAluNegative, iAluOverflow};

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      rState     <= IDLE;
      rOpnd      <= '0;
      rPrio      <= 1'b0;
      rGrant     <= 1'b0;
      rResult0   <= '0;
      rResult1   <= '0;
      rFlags0    <= '0;
      rFlags1    <= '0;
      rRspValid0 <= 1'b0;
      rRspValid1 <= 1'b0;
    end else begin
      case (rState)
        IDLE: begin
          if (pick0 || pick1) begin
            rOpnd  <= pick1 ? {iA1, iB1, iOp1} : {iA0, iB0, iOp0};
            rGrant <= pick1;
            rState <= EXEC;
          end
        end
        EXEC: begin
          if (rGrant) begin
            rResult1   <= iAluResult;
            rFlags1    <= aluFlags;
            rRspValid1 <= 1'b1;
          end else begin
            rResult0   <= iAluResult;
            rFlags0    <= aluFlags;
            rRspValid0 <= 1'b1;
          end
          rState <= RESP;
        end
        RESP: begin
          if (rspDone) begin
            rRspValid0 <= 1'b0;
            rRspValid1 <= 1'b0;
            rPrio      <= !rGrant;
            rState     <= IDLE;
          end
        end
        default: rState <= IDLE;
      endcase
    end
  end

  assign oReqReady0 = pick0 && iRst_n;
  assign oReqReady1 = pick1 && iRst_n;
  assign oRspValid0 = rRspValid0;
  assign oRspValid1 = rRspValid1;
  assign oResult0   = rResult0;
  assign oResult1   = rResult1;
  assign oFlags0    = rFlags0;
  assign oFlags1    = rFlags1;
  assign oAluA      = rOpnd.a;
  assign oAluB      = rOpnd.b;
  assign oAluOp     = rOpnd.op;
  assign oBusy      = (rState != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small reference ALU driving the shared-ALU inputs.
`ifndef ALU_CWIDTH
`define ALU_CWIDTH 4
`endif
`ifndef ALU_OP_ADD
`define ALU_OP_ADD  4'd0
`define ALU_OP_SUBU 4'd3
`define ALU_OP_AND  4'd4
`define ALU_OP_OR   4'd5
`define ALU_OP_CLZ  4'd10
`endif

module tb_alu_arbiter;
  localparam int CW = `ALU_CWIDTH;

  logic iClk = 1'b0;
  always #5 iClk = ~iClk;

  logic          iRst_n;
  logic          iReqValid0, iReqValid1, oReqReady0, oReqReady1;
  logic [31:0]   iA0, iB0, iA1, iB1;
  logic [CW-1:0] iOp0, iOp1;
  logic          oRspValid0, oRspValid1, iRspReady0, iRspReady1;
  logic [31:0]   oResult0, oResult1;
  logic [3:0]    oFlags0, oFlags1;
  logic [31:0]   oAluA, oAluB;
  logic [CW-1:0] oAluOp;
  logic [31:0]   aluRes;
  logic          aluC, aluV;
  logic [32:0]   sum;
  logic          oBusy;

  int nChecks = 0;
  int nBad    = 0;
  int cyc     = 0;

  alu_arbiter #(.CW(CW)) dut (
    .iClk(iClk), .iRst_n(iRst_n),
    .iReqValid0(iReqValid0), .iReqValid1(iReqValid1),
    .oReqReady0(oReqReady0), .oReqReady1(oReqReady1),
    .iA0(iA0), .iB0(iB0), .iA1(iA1), .iB1(iB1),
    .iOp0(iOp0), .iOp1(iOp1),
    .oRspValid0(oRspValid0), .oRspValid1(oRspValid1),
    .iRspReady0(iRspReady0), .iRspReady1(iRspReady1),
    .oResult0(oResult0), .oResult1(oResult1),
    .oFlags0(oFlags0), .oFlags1(oFlags1),
    .oAluA(oAluA), .oAluB(oAluB), .oAluOp(oAluOp),
    .iAluResult(aluRes), .iAluZero(aluRes == 32'd0), .iAluCarry(aluC),
    .iAluNegative(aluRes[31]), .iAluOverflow(aluV),
    .oBusy(oBusy)
  );

  function automatic logic [31:0] clz(input logic [31:0] x);
    logic [31:0] n;
    n = 32;
    for (int i = 0; i < 32; i++) if (x[i]) n = 31 - i;
    return n;
  endfunction

  always_comb begin
    aluRes = '0;
    aluC   = 1'b0;
    aluV   = 1'b0;
    sum    = '0;
    case (oAluOp)
      `ALU_OP_ADD: begin
        sum    = {1'b0, oAluA} + {1'b0, oAluB};
        aluRes = sum[31:0];
        aluC   = sum[32];
        aluV   = (oAluA[31] == oAluB[31]) && (aluRes[31] != oAluA[31]);
      end
      `ALU_OP_SUBU: begin
        aluRes = oAluA - oAluB;
        aluC   = oAluA < oAluB;
      end
      `ALU_OP_AND: aluRes = oAluA & oAluB;
      `ALU_OP_OR:  aluRes = oAluA | oAluB;
      `ALU_OP_CLZ: aluRes = clz(oAluA);
      default:     aluRes = '0;
    endcase
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge iClk);
    #1;
    cyc++;
  endtask

  task automatic waitReady(output int port, input string tag);
    port = -1;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (oReqReady0) begin port = 0; break; end
      if (oReqReady1) begin port = 1; break; end
      tick();
    end
    checkVal({tag, "_found"}, 32'(port >= 0), 1);
  endtask

  // Grants must be mutually exclusive on every cycle.
  always @(negedge iClk) begin
    #2;
    checkVal("rdyExcl", 32'(oReqReady0 & oReqReady1), 0);
  end

  int p;
  int lastCyc;
  logic [31:0] expRes [4];
  initial begin
    expRes[0] = 32'd3; expRes[1] = 32'h300; expRes[2] = 32'hA5; expRes[3] = 32'd5;

    iRst_n = 1'b0;
    iReqValid0 = 1'b1; iA0 = 32'd5;   iB0 = 32'd5;   iOp0 = `ALU_OP_SUBU;
    iReqValid1 = 1'b1; iA1 = 32'hF0;  iB1 = 32'h0F;  iOp1 = `ALU_OP_OR;
    iRspReady0 = 1'b1; iRspReady1 = 1'b1;
    tick(); tick();

    checkVal("rst_rdy0", oReqReady0, 0);
    checkVal("rst_rdy1", oReqReady1, 0);
    checkVal("rst_busy", oBusy, 0);
    checkVal("rst_rv0", oRspValid0, 0);
    checkVal("rst_rv1", oRspValid1, 0);
    checkVal("rst_res0", oResult0, 0);
    checkVal("rst_res1", oResult1, 0);
    checkVal("rst_flg0", oFlags0, 0);
    checkVal("rst_aluA", oAluA, 0);
    checkVal("rst_aluOp", oAluOp, 0);

    // Both requesters pending on the first cycle out of reset.
    iRst_n = 1'b1;
    #1;
    checkVal("t31_rdy0", oReqReady0, 1);
    checkVal("t31_rdy1", oReqReady1, 0);
    tick();
    checkVal("t31_busy", oBusy, 1);
    checkVal("t31_exRdy0", oReqReady0, 0);
    checkVal("t31_aluA", oAluA, 5);
    checkVal("t31_aluOp", oAluOp, `ALU_OP_SUBU);
    checkVal("t31_exRv0", oRspValid0, 0);
    iReqValid0 = 1'b0;
    tick();
    checkVal("t31_rv0", oRspValid0, 1);
    checkVal("t31_res0", oResult0, 0);
    checkVal("t31_flg0", oFlags0, 4'b1000);
    checkVal("t31_rv1lo", oRspValid1, 0);
    tick();
    checkVal("t31_idle", oBusy, 0);
    checkVal("t31_rv0off", oRspValid0, 0);
    checkVal("t31_rdy1b", oReqReady1, 1);
    tick();
    iReqValid1 = 1'b0;
    tick();
    checkVal("t31_rv1", oRspValid1, 1);
    checkVal("t31_res1", oResult1, 32'hFF);
    checkVal("t31_flg1", oFlags1, 4'b0000);
    checkVal("t31_keep0", oResult0, 0);
    checkVal("t31_keepF0", oFlags0, 4'b1000);
    tick();

    // Back-to-back alternation with both held valid.
    iReqValid0 = 1'b1; iA0 = 32'd1;     iB0 = 32'd2;     iOp0 = `ALU_OP_ADD;
    iReqValid1 = 1'b1; iA1 = 32'h100;   iB1 = 32'h200;   iOp1 = `ALU_OP_ADD;
    lastCyc = 0;
    for (int k = 0; k < 4; k++) begin
      waitReady(p, "t32");
      checkVal("t32_gnt", p, k % 2);
      if (k > 0) checkVal("t32_gap", cyc - lastCyc, 3);
      lastCyc = cyc;
      tick();
      if (p == 0) begin
        if (k < 2) begin iA0 = 32'hA0; iB0 = 32'h05; iOp0 = `ALU_OP_OR; end
        else iReqValid0 = 1'b0;
      end else begin
        if (k < 2) begin iA1 = 32'd9; iB1 = 32'd4; iOp1 = `ALU_OP_SUBU; end
        else iReqValid1 = 1'b0;
      end
      tick();
      checkVal("t32_rv", (p == 1) ? oRspValid1 : oRspValid0, 1);
      checkVal("t32_res", (p == 1) ? oResult1 : oResult0, expRes[k]);
      tick();
    end

    // Signed overflow on port 0 alone.
    iReqValid0 = 1'b1; iA0 = 32'h7FFF_FFFF; iB0 = 32'h1; iOp0 = `ALU_OP_ADD;
    waitReady(p, "t30");
    checkVal("t30_gnt", p, 0);
    checkVal("t30_rdy1", oReqReady1, 0);
    tick();
    iReqValid0 = 1'b0;
    checkVal("t30_rvEarly", oRspValid0, 0);
    tick();
    checkVal("t30_rv0", oRspValid0, 1);
    checkVal("t30_res0", oResult0, 32'h8000_0000);
    checkVal("t30_flg0", oFlags0, 4'b0011);
    checkVal("t30_rv1", oRspValid1, 0);
    checkVal("t30_keep1", oResult1, 5);
    tick();

    // Stalled consumer on port 1 blocks port 0.
    iRspReady1 = 1'b0;
    iReqValid1 = 1'b1; iA1 = 32'd0; iB1 = 32'd0; iOp1 = `ALU_OP_CLZ;
    waitReady(p, "t33");
    checkVal("t33_gnt", p, 1);
    tick();
    iReqValid1 = 1'b0;
    iReqValid0 = 1'b1; iA0 = 32'd2; iB0 = 32'd2; iOp0 = `ALU_OP_ADD;
    tick();
    for (int i = 0; i < 5; i++) begin
      checkVal("t33_rv1", oRspValid1, 1);
      checkVal("t33_res1", oResult1, 32'h20);
      checkVal("t33_busy", oBusy, 1);
      checkVal("t33_rdy0", oReqReady0, 0);
      tick();
    end
    iRspReady1 = 1'b1;
    #1;
    checkVal("t33_hsRdy0", oReqReady0, 0);
    tick();
    checkVal("t33_rv1off", oRspValid1, 0);
    checkVal("t33_rdy0go", oReqReady0, 1);
    checkVal("t33_keep1", oResult1, 32'h20);
    tick();
    iReqValid0 = 1'b0;
    tick();
    checkVal("t33_res0", oResult0, 4);
    tick();

    // Reset while an operation is in EXEC.
    iReqValid1 = 1'b1; iA1 = 32'd3; iB1 = 32'd3; iOp1 = `ALU_OP_ADD;
    waitReady(p, "t34");
    checkVal("t34_gnt", p, 1);
    tick();
    iReqValid1 = 1'b0;
    checkVal("t34_busy", oBusy, 1);
    checkVal("t34_aluA", oAluA, 3);
    iReqValid0 = 1'b1; iA0 = 32'd5; iB0 = 32'd6; iOp0 = `ALU_OP_ADD;
    iRst_n = 1'b0;
    #1;
    checkVal("t34_rBusy", oBusy, 0);
    checkVal("t34_rAluA", oAluA, 0);
    checkVal("t34_rRes0", oResult0, 0);
    checkVal("t34_rRes1", oResult1, 0);
    checkVal("t34_rRv1", oRspValid1, 0);
    checkVal("t34_rRdy0", oReqReady0, 0);
    tick(); tick();
    iRst_n = 1'b1;
    #1;
    checkVal("t34_rdy0", oReqReady0, 1);
    tick();
    iReqValid0 = 1'b0;
    checkVal("t34_noRv1a", oRspValid1, 0);
    tick();
    checkVal("t34_noRv1b", oRspValid1, 0);
    checkVal("t34_rv0", oRspValid0, 1);
    checkVal("t34_res0", oResult0, 32'd11);
    tick();

    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

endmodule
